// File: rtl/benes_perm_pipe_if.sv
// benes_perm_pipe_if: stream and configuration handshake bundle for benes_perm_pipe
interface benes_perm_pipe_if #(
    parameter int N = 32,
    parameter int P = 32
);
    localparam int CW = (P / 2) * (2 * $clog2(P) - 1);
    logic in_valid, in_ready, out_valid, out_ready;
    logic cfg_wr_en, cfg_commit, cfg_busy;
    logic [P*N-1:0] in_data, out_data;
    logic [CW-1:0] cfg_wr_data;
    modport master(
        output in_valid, in_data, out_ready, cfg_wr_en, cfg_wr_data, cfg_commit,
        input in_ready, out_valid, out_data, cfg_busy
    );
    modport slave(
        input in_valid, in_data, out_ready, cfg_wr_en, cfg_wr_data, cfg_commit,
        output in_ready, out_valid, out_data, cfg_busy
    );
endinterface

// File: rtl/benes_perm_pipe.sv
// benes_perm_pipe: fully pipelined P-lane Benes network with double-buffered per-switch routing.
// Defining BENES_PERF_CNT_EN adds the perf_beats/perf_stalls output counters.
module benes_perm_pipe #(
    parameter int N = 32,
    parameter int P = 32
) (
    input logic clk,
    input logic rst,
    benes_perm_pipe_if.slave bus
`ifdef BENES_PERF_CNT_EN
    ,
    output logic [31:0] perf_beats,
    output logic [31:0] perf_stalls
`endif
);
    localparam int LP = $clog2(P);
    localparam int S = 2 * LP - 1;
    localparam int CW = (P / 2) * S;
    typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;
    state_t state, nxt;
    logic [CW-1:0] act, shd;
    logic [S-1:0] v, vin;
    logic [P*N-1:0] stg [S];
    logic [P*N-1:0] x [S];
    logic [P*N-1:0] col [S];
    logic adv, acc;

    function automatic int cw(int m);
        return (m / 2) * (2 * $clog2(m) - 1);
    endfunction

    // Stage s sits at recursion depth s (entry columns) or S-1-s (exit columns); lanes of a
    // block are either paired (2k, 2k+1) or split across the two halves (k, h+k).
    function automatic int pos(int s, int j, int port, bit outp);
        int h = (P >> (s < LP ? s : S - 1 - s)) / 2;
        int b = j / h;
        int k = j % h;
        return ((s < LP) ^ outp) ? 2 * b * h + 2 * k + port : 2 * b * h + port * h + k;
    endfunction

    function automatic int cidx(int s, int j);
        int d = s < LP ? s : S - 1 - s;
        int h = (P >> d) / 2;
        int b = j / h;
        int k = j % h;
        int m = P;
        int base = 0;
        for (int l = 0; l < d; l++) begin
            base += m / 2 + (((b >> (d - l - 1)) & 1) != 0 ? 0 : cw(m / 2));
            m /= 2;
        end
        return m == 2 ? base : s < LP ? base + cw(m) - 1 - k : base + m / 2 - 1 - k;
    endfunction

    assign adv = !v[S-1] || bus.out_ready;
    assign bus.in_ready = adv && state == RUN && !rst;
    assign acc = bus.in_valid && bus.in_ready;
    assign vin = S'({v, acc});
    assign bus.out_valid = v[S-1];
    assign bus.out_data = stg[S-1];
    assign bus.cfg_busy = state != RUN;

    always_comb begin
        x = '{default: '0};
        col = '{default: '0};
        x[0] = bus.in_data;
        for (int s = 1; s < S; s++) x[s] = stg[s-1];
        for (int s = 0; s < S; s++) begin
            for (int j = 0; j < P / 2; j++) begin
                col[s][pos(s, j, 0, 1)*N +: N] = act[cidx(s, j)] ? x[s][pos(s, j, 1, 0)*N +: N] : x[s][pos(s, j, 0, 0)*N +: N];
                col[s][pos(s, j, 1, 1)*N +: N] = act[cidx(s, j)] ? x[s][pos(s, j, 0, 0)*N +: N] : x[s][pos(s, j, 1, 0)*N +: N];
            end
        end
    end

    always_comb begin
        nxt = state;
        nxt = state == RUN ? (bus.cfg_commit ? DRAIN : RUN) : state == DRAIN ? (v == '0 ? SWAP : DRAIN) : RUN;
    end

    // Active routing only changes once the pipe is empty, so every stage can share it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            act <= '0;
            shd <= '0;
            v <= '0;
            for (int s = 0; s < S; s++) stg[s] <= '0;
        end else begin
            state <= nxt;
            if (bus.cfg_wr_en && state == RUN) shd <= bus.cfg_wr_data;
            if (state == SWAP) act <= shd;
            if (adv) begin
                v <= vin;
                for (int s = 0; s < S; s++) if (vin[s]) stg[s] <= col[s];
            end
        end
    end

`ifdef BENES_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_beats <= '0;
            perf_stalls <= '0;
        end else begin
            perf_beats <= perf_beats + 32'(bus.out_valid && bus.out_ready);
            perf_stalls <= perf_stalls + 32'(bus.out_valid && !bus.out_ready);
        end
    end
`endif
endmodule

// File: tb/tb_benes_perm_pipe.sv
// tb_benes_perm_pipe: randomized scoreboard bench for benes_perm_pipe against a block-recursive Benes model
module tb_benes_perm_pipe;
    localparam int N = 32;
    localparam int P = 32;
    localparam int LP = $clog2(P);

    function automatic int cwr(int m);
        int r = 1;
        for (int q = 4; q <= m; q *= 2) r = q + 2 * r;
        return r;
    endfunction

    localparam int CW = cwr(P);

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    benes_perm_pipe_if #(.N(N), .P(P)) b();
`ifdef BENES_PERF_CNT_EN
    logic [31:0] perf_beats, perf_stalls;
    benes_perm_pipe #(.N(N), .P(P)) dut(.clk(clk), .rst(rst), .bus(b), .perf_beats(perf_beats), .perf_stalls(perf_stalls));
`else
    benes_perm_pipe #(.N(N), .P(P)) dut(.clk(clk), .rst(rst), .bus(b));
`endif

    int checks = 0, errors = 0, cyc_n = 0;
    int nfire = 0, nstall = 0, last_fire_cyc = 0;
    bit last_acc, prev_stall = 0;
    logic [P*N-1:0] prev_data;
    logic [P*N-1:0] expq [$];
    logic [CW-1:0] mcfg = '0;
    logic [P*N-1:0] pat_id, pat_sw;

    // Reference: each Benes(M) block splits into halves via its first column, recurses, then merges.
    function automatic logic [P*N-1:0] model(input logic [P*N-1:0] din, input logic [CW-1:0] c);
        logic [N-1:0] a [P];
        logic [N-1:0] t [P];
        logic [N-1:0] tmp;
        int bs [LP][P];
        logic [P*N-1:0] r;
        int m, h;
        bit sw;
        for (int i = 0; i < P; i++) a[i] = din[i*N +: N];
        bs[0][0] = 0;
        for (int d = 0; d < LP - 1; d++) begin
            m = P >> d;
            for (int bb = 0; bb < (1 << d); bb++) begin
                bs[d+1][2*bb] = bs[d][bb] + m / 2 + cwr(m / 2);
                bs[d+1][2*bb+1] = bs[d][bb] + m / 2;
            end
        end
        for (int d = 0; d < LP - 1; d++) begin
            m = P >> d;
            h = m / 2;
            for (int bb = 0; bb < (1 << d); bb++)
                for (int k = 0; k < h; k++) begin
                    sw = c[bs[d][bb] + cwr(m) - 1 - k];
                    t[bb*m+k] = sw ? a[bb*m+2*k+1] : a[bb*m+2*k];
                    t[bb*m+h+k] = sw ? a[bb*m+2*k] : a[bb*m+2*k+1];
                end
            a = t;
        end
        for (int bb = 0; bb < P / 2; bb++)
            if (c[bs[LP-1][bb]]) begin
                tmp = a[2*bb];
                a[2*bb] = a[2*bb+1];
                a[2*bb+1] = tmp;
            end
        for (int d = LP - 2; d >= 0; d--) begin
            m = P >> d;
            h = m / 2;
            for (int bb = 0; bb < (1 << d); bb++)
                for (int k = 0; k < h; k++) begin
                    sw = c[bs[d][bb] + h - 1 - k];
                    t[bb*m+2*k] = sw ? a[bb*m+h+k] : a[bb*m+k];
                    t[bb*m+2*k+1] = sw ? a[bb*m+k] : a[bb*m+h+k];
                end
            a = t;
        end
        for (int i = 0; i < P; i++) r[i*N +: N] = a[i];
        return r;
    endfunction

    function automatic logic [P*N-1:0] rnd_data();
        logic [P*N-1:0] r;
        for (int i = 0; i < P; i++) r[i*N +: N] = $urandom;
        return r;
    endfunction

    function automatic logic [CW-1:0] rnd_cfg();
        logic [CW-1:0] r;
        for (int i = 0; i < CW; i++) r[i] = 1'($urandom & 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [P*N-1:0] got, input logic [P*N-1:0] exp);
        int j;
        j = 0;
        checks++;
        if (got !== exp) begin
            errors++;
            for (int i = P - 1; i >= 0; i--) if (got[i*N +: N] !== exp[i*N +: N]) j = i;
            $display("FAIL %s: lane %0d is %h, expected %h", tag, j, got[j*N +: N], exp[j*N +: N]);
        end
    endtask

    // One clock: sample at mid-cycle, score outputs, log accepted beats, then advance past the edge.
    task automatic step();
        #1;
        last_acc = 0;
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_valid", b.out_valid, 1);
                chk("hold_data", b.out_data, prev_data);
            end
            if ((b.out_valid && !b.out_ready) || b.cfg_busy) chk("in_ready_low", b.in_ready, 0);
            if (b.out_valid && b.out_ready) begin
                last_fire_cyc = cyc_n;
                nfire++;
                chk("queue_nonempty", expq.size() > 0, 1);
                if (expq.size() > 0) chk("beat", b.out_data, expq.pop_front());
            end
            if (b.out_valid && !b.out_ready) nstall++;
            if (b.in_valid && b.in_ready) begin
                last_acc = 1;
                expq.push_back(model(b.in_data, mcfg));
            end
            prev_stall = b.out_valid && !b.out_ready;
            prev_data = b.out_data;
        end else begin
            chk("rst_in_ready", b.in_ready, 0);
            expq.delete();
            prev_stall = 0;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic send(input logic [P*N-1:0] d, output int acc_c);
        b.in_valid = 1;
        b.in_data = d;
        acc_c = -1;
        for (int n = 0; n < 60 && acc_c < 0; n++) begin
            step();
            if (last_acc) acc_c = cyc_n - 1;
        end
        if (acc_c < 0) chk("send_timeout", last_acc, 1);
        b.in_valid = 0;
    endtask

    task automatic wait_out();
        for (int n = 0; n < 40 && !b.out_valid; n++) step();
        chk("out_timeout", b.out_valid, 1);
    endtask

    task automatic drain();
        b.in_valid = 0;
        b.out_ready = 1;
        for (int n = 0; n < 60 && expq.size() > 0; n++) step();
        chk("drained", expq.size(), 0);
    endtask

    task automatic commit(input logic [CW-1:0] c);
        for (int n = 0; n < 60 && b.cfg_busy; n++) step();
        chk("idle_timeout", b.cfg_busy, 0);
        b.cfg_wr_en = 1;
        b.cfg_wr_data = c;
        b.cfg_commit = 1;
        step();
        mcfg = c;
        b.cfg_wr_en = 0;
        b.cfg_commit = 0;
        chk("commit_busy", b.cfg_busy, 1);
        chk("commit_in_ready", b.in_ready, 0);
    endtask

    initial begin
        int ac, sent, off_c, f0, s0;
        logic [CW-1:0] pc, newc;
        for (int i = 0; i < P; i++) pat_id[i*N +: N] = 32'(i + 1);
        for (int k = 0; k < P / 2; k++) begin
            pat_sw[2*k*N +: N] = 32'(2 * k + 2);
            pat_sw[(2*k+1)*N +: N] = 32'(2 * k + 1);
        end
        b.in_valid = 0;
        b.in_data = '0;
        b.out_ready = 1;
        b.cfg_wr_en = 0;
        b.cfg_wr_data = '0;
        b.cfg_commit = 0;
        rst = 1;
        repeat (3) step();
        chk("rst_out_valid", b.out_valid, 0);
        chk("rst_out_data", b.out_data, '0);
        chk("rst_busy", b.cfg_busy, 0);
        rst = 0;

        send(pat_id, ac);
        wait_out();
        chk("id_latency", cyc_n - ac, 9);
        chk("id_data", b.out_data, pat_id);
        step();

        pc = '0;
        pc[15:0] = 16'hFFFF;
        commit(pc);
        send(pat_id, ac);
        wait_out();
        chk("swap_data", b.out_data, pat_sw);
        drain();

        for (int r = 0; r < 4; r++) begin
            commit(rnd_cfg());
            for (int c = 0; c < 60; c++) begin
                b.in_valid = ($urandom % 4) != 0;
                b.in_data = rnd_data();
                b.out_ready = ($urandom % 3) != 0;
                step();
            end
            drain();
        end

        sent = 0;
        f0 = nfire;
        s0 = nstall;
        for (int c = 0; c < 100 && (sent < 12 || expq.size() > 0); c++) begin
            b.in_valid = sent < 12;
            b.in_data = rnd_data();
            b.out_ready = !(c >= 10 && c <= 14);
            step();
            sent += int'(last_acc);
        end
        b.in_valid = 0;
        b.out_ready = 1;
        chk("bp_beats", nfire - f0, 12);
        chk("bp_stalls", nstall - s0, 5);

        newc = rnd_cfg();
        for (int i = 0; i < 3; i++) begin
            b.in_valid = 1;
            b.in_data = rnd_data();
            step();
            chk("mid_accept", last_acc, 1);
        end
        b.in_valid = 0;
        commit(newc);
        b.cfg_wr_en = 1;
        b.cfg_wr_data = ~newc;
        b.cfg_commit = 1;
        step();
        b.cfg_wr_en = 0;
        b.cfg_commit = 0;
        chk("second_commit_busy", b.cfg_busy, 1);
        off_c = -1;
        b.in_valid = 1;
        b.in_data = rnd_data();
        for (int n = 0; n < 40; n++) begin
            if (!b.cfg_busy && off_c < 0) off_c = cyc_n;
            step();
            if (last_acc) break;
        end
        chk("new_beat_accepted", last_acc, 1);
        chk("swap_timing", off_c - last_fire_cyc, 3);
        drain();

        commit(rnd_cfg());
        sent = 0;
        for (int n = 0; n < 60 && sent < 9; n++) begin
            b.in_valid = 1;
            b.in_data = rnd_data();
            step();
            sent += int'(last_acc);
        end
        b.in_valid = 0;
        chk("full_before_rst", b.out_valid, 1);
        rst = 1;
        step();
        rst = 0;
        mcfg = '0;
        chk("rst_mid_out_valid", b.out_valid, 0);
        chk("rst_mid_busy", b.cfg_busy, 0);
        send(pat_id, ac);
        wait_out();
        chk("rst_identity", b.out_data, pat_id);
        drain();

`ifdef BENES_PERF_CNT_EN
        rst = 1;
        step();
        rst = 0;
        chk("perf_rst_beats", perf_beats, 0);
        chk("perf_rst_stalls", perf_stalls, 0);
        sent = 0;
        f0 = nfire;
        s0 = nstall;
        for (int c = 0; c < 100 && nfire - f0 < 12; c++) begin
            b.in_valid = sent < 12;
            b.in_data = rnd_data();
            b.out_ready = !(b.out_valid && nstall - s0 < 5);
            step();
            sent += int'(last_acc);
        end
        b.in_valid = 0;
        b.out_ready = 1;
        chk("perf_beats", perf_beats, 12);
        chk("perf_stalls", perf_stalls, 5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/benes_perm_pipe.md
# benes_perm_pipe

Parameterised, fully pipelined Benes permutation network carrying P lanes of N-bit data, with a valid/ready stream interface. Routing is set per switch, not per column, through a double-buffered configuration register; a new configuration takes effect only after the pipeline drains. The block sits between the feature-map buffers and the PE array in the CNN datapath, where it reorders operand lanes.

## Interface
- `N`, 32: lane data width in bits.
- `P`, 32: lane count; power of two, ≥2. `LP = log2(P)`.
- `S` (localparam): stage count, `2*LP-1` (9 at P=32).
- `CW` (localparam): configuration width, `CW(2)=1`, `CW(P)=P+2*CW(P/2)` (`(P/2)*S`, 144 at P=32).
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `in_data`  in  P*N  lane i at `[i*N +: N]`.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  downstream accepts the output beat.
- `out_data`  out  P*N  lane j at `[j*N +: N]`.
- `cfg_wr_en`  in  1  load `cfg_wr_data` into the shadow register.
- `cfg_wr_data`  in  CW  switch settings; 1 = cross, 0 = bar.
- `cfg_commit`  in  1  request shadow→active swap.
- `cfg_busy`  out  1  commit in progress.
- `perf_beats`, `perf_stalls`  out  32 each  present only with `BENES_PERF_CNT_EN`.

## Operation
- Topology is defined recursively:
  - First column: switch k takes lanes 2k and 2k+1. Its upper output drives input k of the upper sub-network; its lower output drives input k of the lower sub-network.
  - Each sub-network is a Benes(P/2).
  - Last column: switch k takes output k of the upper sub-network and output k of the lower sub-network, and drives lanes 2k and 2k+1.
- Switch behaviour: bar gives y1=x1, y2=x2. Cross gives y1=x2, y2=x1.
- Config packing, MSB to LSB: first column (P/2 bits, switch 0 at MSB), upper sub-network config, lower sub-network config, last column (P/2 bits, switch 0 at MSB of that field).
- An all-zero config gives the identity permutation.
- Each of the S columns is followed by a register stage with its own valid bit.
- States: RUN, DRAIN, SWAP.
  - RUN: a `cfg_commit` with `cfg_busy`=0 moves to DRAIN.
  - DRAIN: moves to SWAP when every stage valid bit is 0.
  - SWAP: one cycle; active ← shadow; returns to RUN.
- `cfg_busy` = 1 in DRAIN and SWAP.
- `cfg_wr_en` writes the shadow register only while `cfg_busy`=0.
- `cfg_commit` is ignored while `cfg_busy`=1.
- `cfg_wr_en` and `cfg_commit` in the same cycle: the new shadow value is the one committed.
- In-flight beats always complete with the configuration that was active when they entered.

## Timing
- Advance condition: `adv = !out_valid | out_ready`. All stages shift together on `adv`. With `adv`=0 every stage holds and `out_data` is stable.
- `in_ready = adv & (state==RUN)`. `in_ready` is combinational from registered state and `out_ready`.
- A `cfg_commit` in the same cycle as an accepted beat: the beat is accepted, and `in_ready` drops on the next cycle.
- Latency: S cycles from acceptance to `out_valid` with no stall. Throughput: 1 beat per cycle.
- Commit cost: the drain (≤S cycles) plus 1 SWAP cycle. The first new beat is accepted on the cycle after SWAP.
- Reset values: `out_valid`=0, `out_data`=0, all stage valid and data bits 0, active config 0, shadow config 0, state RUN, `cfg_busy`=0, perf counters 0.
- `in_ready`=0 while `rst`=1.
- Reset mid-stream discards every in-flight beat; it is not flushed to the output.

## Configuration
- `BENES_PERF_CNT_EN` defined:
  - `perf_beats` increments on each `out_valid & out_ready`.
  - `perf_stalls` increments on each `out_valid & !out_ready`.
  - Both wrap modulo 2^32 and clear on `rst`.
- `BENES_PERF_CNT_EN` undefined: both ports and counters are absent. Datapath behaviour and timing are identical to the enabled build.

## Test plan
All tests use N=32, P=32.
- Identity: after reset, hold `out_ready`=1 and send in lane i = i+1 → out lane i = i+1, with `out_valid` exactly 9 cycles after acceptance.
- Pair swap: write cfg with only the last column set (low 16 bits = 16'hFFFF), commit, then send lane i = i+1 → out lane 2k = 2k+2 and out lane 2k+1 = 2k+1.
- Backpressure: stream 12 beats while `out_ready`=0 for cycles 10–14 → `in_ready` drops while the pipeline is full, `out_data` holds, all 12 beats emerge in order with none lost or duplicated.
- Commit mid-stream: 3 beats in flight, then `cfg_commit` → `cfg_busy`=1, `in_ready`=0, the 3 beats exit with the old mapping, SWAP occurs one cycle after the last beat leaves, and the next beat uses the new mapping. A second commit during busy is ignored.
- Reset mid-operation: assert `rst` with 9 beats in flight → next cycle `out_valid`=0, active config 0, and a following beat is routed as identity.
- Perf counters (macro on): 5 stall cycles and 12 transfers → `perf_stalls`=5, `perf_beats`=12.
